byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
Sits directly downstream of the APF byte data loader, in the clk_memory domain. Consumes its byte-wide write strobe stream and packs little-endian byte pairs into 16-bit word writes with per-byte enables. Buffers the words in a small FIFO and presents them to a 16-bit memory controller (SDRAM/PSRAM arbiter port) over a valid/ready handshake. Non-sequential and partial bytes are emitted as masked partial words, so no data is lost.

Parameters:
ADDRESS_SIZE, 14, input byte address is [ADDRESS_SIZE:0]; output word address is [ADDRESS_SIZE:1].
FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 word entries (default 4).

Ports:
clk_memory  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
in_write_en  in  1  byte write strobe; one byte per asserted cycle
in_write_addr  in  ADDRESS_SIZE+1  byte address
in_write_data  in  8  byte data
flush  in  1  one-cycle pulse; forces a held partial word out
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer accepts the head when out_valid && out_ready
out_addr  out  ADDRESS_SIZE  word address, equal to byte address [ADDRESS_SIZE:1]
out_data  out  16  [7:0] is the even byte, [15:8] is the odd byte
out_byte_en  out  2  bit0 means the even lane is valid; bit1 means the odd lane is valid
busy  out  1  pend_valid or FIFO not empty
overflow  out  1  sticky; set when a byte is dropped; cleared only by reset

Behaviour:
- Reset: all of the following are forced to 0: out_valid, out_addr, out_data, out_byte_en, busy, overflow, pend_valid, FIFO pointers and count. Reset mid-operation discards the pend register and all FIFO contents.
- Pend register holds at most one word: pend_addr, pend_data, pend_be.
- Lane select: lane = in_write_addr[0]. The byte goes to pend_data[8*lane +: 8] and sets pend_be[lane]. Word address = in_write_addr[ADDRESS_SIZE:1].
- The FIFO accepts at most one push per cycle.
- A push is required this cycle when pend_valid and any of the following hold:
  (a) pend_be[1] is set (lane 1 written; the word is complete or odd-only);
  (b) in_write_en and the word address differs from pend_addr;
  (c) in_write_en and lane 0 is already set in pend_be (even byte rewritten);
  (d) flush.
- Input with no required push, pend empty: load the byte; pend_be = the lane bit.
- Input with no required push, matching word and lane 1: merge; pend_be = 11. The word is pushed on the next cycle under rule (a).
- Input with a required push: push the old pend to the FIFO and load the new byte as a fresh pend, in the same cycle.
- Resulting latency: odd byte at cycle N gives a FIFO write at edge N+1 and out_valid at N+2 (FIFO empty, registered output).
- FIFO full while a push is required and no input: hold the pend; no loss; retry each cycle.
- FIFO full while a push is required and in_write_en: the new byte is dropped, the pend is held, and overflow is set.
- FIFO full, pend empty, in_write_en: load normally (no push needed).
- A pop on the same cycle as a push while full frees space. The push is allowed in that cycle; the full flag is computed as count == depth && !pop.
- Output handshake: out_addr, out_data and out_byte_en are stable while out_valid && !out_ready. They advance only on a pop.
- busy: combinational OR of pend_valid and (count != 0).
- flush with pend empty: no effect. flush coincident with input: treated as a required push; the new byte becomes the pend.
- FIFO pointers wrap modulo the depth; count is FIFO_DEPTH_LOG2+1 bits wide.

Test Plan:
- Sequential pair: bytes 0xAA at 0x0010 and 0xBB at 0x0011, 3 cycles apart, out_ready=1 -> one entry with addr 0x0008, data 0xBBAA, be 11; out_valid for exactly 1 cycle.
- Four bytes 11,22,33,44 at 0x0100-0x0103 -> words (0x0080, 0x2211, 11) then (0x0081, 0x4433, 11), in order.
- Gap: 0x55 at 0x0020, then 0x66 at 0x0030 -> (0x0010, 0x0055, 01) emitted when the second byte arrives; 0x66 is held until flush; flush -> (0x0018, 0x0066, 01).
- Odd-only: 0x77 at 0x0041 with pend empty -> (0x0020, 0x7700, 10), out_valid 2 cycles after the strobe.
- Backpressure: out_ready=0, write 10 sequential bytes -> 4 FIFO entries plus a held pend, then the next push with input drops the byte and overflow=1. Release out_ready -> 4 words drain in order; busy stays 1 until the pend also drains.
- Reset mid-stream: reset asserted with 2 FIFO entries and a partial pend -> the next cycle out_valid=0, busy=0, overflow=0; a following pair packs correctly.

Source files
------------

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a little-endian byte write stream into 16-bit word
// writes with per-byte enables, buffered in a small FIFO behind a
// valid/ready handshake toward a 16-bit memory controller.
module byte_word_packer #(
  parameter int ADDRESS_SIZE    = 14,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    in_write_en,
  input  logic [ADDRESS_SIZE:0]   in_write_addr,
  input  logic [7:0]              in_write_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_SIZE-1:0] out_addr,
  output logic [15:0]             out_data,
  output logic [1:0]              out_byte_en,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG2:0];

  // Pend register (one partially or fully assembled word)
  logic                    pend_valid_q, pend_valid_d;
  logic [ADDRESS_SIZE-1:0] pend_addr_q,  pend_addr_d;
  logic [15:0]             pend_data_q,  pend_data_d;
  logic [1:0]              pend_be_q,    pend_be_d;

  // FIFO control
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q,  count_d;
  logic                       overflow_q, overflow_d;

  // FIFO storage (data only, never reset)
  logic [ADDRESS_SIZE-1:0] mem_addr_q [DEPTH];
  logic [15:0]             mem_data_q [DEPTH];
  logic [1:0]              mem_be_q   [DEPTH];

  logic                    in_lane;
  logic [ADDRESS_SIZE-1:0] in_waddr;
  logic                    pop;
  logic                    fifo_full;
  logic                    push_req;
  logic                    push;
  logic [15:0]             fresh_data;
  logic [1:0]              fresh_be;

  assign in_lane    = in_write_addr[0];
  assign in_waddr   = in_write_addr[ADDRESS_SIZE:1];
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  // A same-cycle pop makes room, so a full FIFO can still take the push.
  assign fifo_full  = (count_q == DEPTH_CNT) && !pop;
  // Lane 1 held, a different word arriving, an already-held lane being
  // rewritten, or an explicit flush all force the pend word out.
  assign push_req   = pend_valid_q &&
                      (pend_be_q[1] ||
                       (in_write_en && ((in_waddr != pend_addr_q) || pend_be_q[in_lane])) ||
                       flush);
  assign push       = push_req && !fifo_full;
  assign fresh_data = in_lane ? {in_write_data, 8'h00} : {8'h00, in_write_data};
  assign fresh_be   = in_lane ? 2'b10 : 2'b01;

  assign out_addr    = out_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign out_data    = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_byte_en = out_valid ? mem_be_q[rd_ptr_q]   : '0;
  assign busy        = pend_valid_q || (count_q != '0);
  assign overflow    = overflow_q;

  // Next-state for the pend word, FIFO pointers/count and overflow flag
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (push_req) begin
      if (!fifo_full) begin
        if (in_write_en) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = in_waddr;
          pend_data_d  = fresh_data;
          pend_be_d    = fresh_be;
        end else begin
          pend_valid_d = 1'b0;
        end
      end else if (in_write_en) begin
        // No room and no way to hold two words: the new byte is lost.
        overflow_d = 1'b1;
      end
    end else if (in_write_en) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = in_waddr;
        pend_data_d  = fresh_data;
        pend_be_d    = fresh_be;
      end else begin
        // Only reachable as the odd byte of the held even byte's word.
        pend_data_d[15:8] = in_write_data;
        pend_be_d         = 2'b11;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
    if (push && !pop)      count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
    else if (pop && !push) count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_memory) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Pend word contents; meaningful only while pend_valid_q is set
  always_ff @(posedge clk_memory) begin
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
    pend_be_q   <= pend_be_d;
  end

  // FIFO storage write on push
  always_ff @(posedge clk_memory) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= pend_addr_q;
      mem_data_q[wr_ptr_q] <= pend_data_q;
      mem_be_q[wr_ptr_q]   <= pend_be_q;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: directed scenarios with literal expectations plus a
// randomized stream, all compared against a queue-based reference model.
module tb_byte_word_packer;

  localparam int AS    = 14;
  localparam int LG    = 2;
  localparam int DEPTH = 1 << LG;

  logic          clk_memory = 1'b0;
  logic          reset      = 1'b1;
  logic          in_write_en = 1'b0;
  logic [AS:0]   in_write_addr = '0;
  logic [7:0]    in_write_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AS-1:0] out_addr;
  logic [15:0]   out_data;
  logic [1:0]    out_byte_en;
  logic          busy;
  logic          overflow;

  byte_word_packer #(.ADDRESS_SIZE(AS), .FIFO_DEPTH_LOG2(LG)) dut (
    .clk_memory   (clk_memory),
    .reset        (reset),
    .in_write_en  (in_write_en),
    .in_write_addr(in_write_addr),
    .in_write_data(in_write_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_byte_en  (out_byte_en),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk_memory = ~clk_memory;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: list of words waiting to be accepted, plus the word
  // currently being assembled.
  typedef struct { int addr; int data; int be; } word_t;
  word_t m_q[$];
  bit    m_pv;
  int    m_pa, m_pd, m_pbe;
  bit    m_ovf;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_load(int wa, int lane, int data);
    m_pv  = 1'b1;
    m_pa  = wa;
    m_pd  = data << (8 * lane);
    m_pbe = 1 << lane;
  endtask

  task automatic model_step(bit we, int addr, int data, bit fl, bit rdy, bit rst);
    int  lane, wa;
    bit  popped, full, must_emit;
    word_t w;
    if (rst) begin
      m_q.delete();
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    lane = addr % 2;
    wa   = addr / 2;
    popped = (m_q.size() > 0) && rdy;
    full   = (m_q.size() == DEPTH) && !popped;
    // The pend word must leave when it can no longer grow: its odd byte is
    // in, another word's byte arrives, a held byte would be overwritten, or
    // the caller flushes.
    must_emit = m_pv && ((m_pbe == 2 || m_pbe == 3) || fl ||
                         (we && (wa != m_pa || ((m_pbe >> lane) % 2 == 1))));
    if (popped) void'(m_q.pop_front());
    if (must_emit) begin
      if (!full) begin
        w.addr = m_pa; w.data = m_pd; w.be = m_pbe;
        m_q.push_back(w);
        if (we) model_load(wa, lane, data);
        else m_pv = 1'b0;
      end else if (we) begin
        m_ovf = 1'b1;
      end
    end else if (we) begin
      if (!m_pv) model_load(wa, lane, data);
      else begin
        m_pd  = m_pd + (data << (8 * lane));
        m_pbe = m_pbe + (1 << lane);
      end
    end
  endtask

  task automatic compare_model();
    check("m_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    check("m_busy", {31'd0, busy}, {31'd0, (m_pv || m_q.size() != 0)});
    check("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_q.size() != 0) begin
      check("m_addr", 32'(out_addr), m_q[0].addr);
      check("m_data", 32'(out_data), m_q[0].data);
      check("m_be", 32'(out_byte_en), m_q[0].be);
    end
  endtask

  // One clock: compare on the falling edge, drive, advance the model,
  // then return at the rising edge.
  task automatic cycle(bit we, int addr, int data, bit fl, bit rdy, bit rst);
    @(negedge clk_memory);
    if (chk_en) compare_model();
    in_write_en   = we;
    in_write_addr = addr[AS:0];
    in_write_data = data[7:0];
    flush         = fl;
    out_ready     = rdy;
    reset         = rst;
    model_step(we, addr, data, fl, rdy, rst);
    if (rst) chk_en = 1'b1;
    @(posedge clk_memory);
  endtask

  task automatic wr(int addr, int data, bit rdy);
    cycle(1'b1, addr, data, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(bit rdy);
    cycle(1'b0, 0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic pin_word(string n, int a, int d, int be);
    #2;
    check({n, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({n, "_addr"}, 32'(out_addr), a);
    check({n, "_data"}, 32'(out_data), d);
    check({n, "_be"}, 32'(out_byte_en), be);
  endtask

  initial begin
    int cursor;
    int a;
    bit we, fl, rdy, rst;

    // Reset state
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_be", 32'(out_byte_en), 32'd0);

    // Sequential pair three cycles apart
    wr(32'h0010, 32'hAA, 1'b1);
    idle(1'b1);
    idle(1'b1);
    wr(32'h0011, 32'hBB, 1'b1);
    #2 check("pair_early", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    pin_word("pair", 32'h0008, 32'hBBAA, 3);
    idle(1'b1);
    #2 check("pair_once", {31'd0, out_valid}, 32'd0);

    // Four bytes, two words in order
    wr(32'h0100, 32'h11, 1'b1);
    wr(32'h0101, 32'h22, 1'b1);
    wr(32'h0102, 32'h33, 1'b1);
    pin_word("four0", 32'h0080, 32'h2211, 3);
    wr(32'h0103, 32'h44, 1'b1);
    idle(1'b1);
    pin_word("four1", 32'h0081, 32'h4433, 3);
    idle(1'b1);

    // Address gap, then flush of the held byte
    wr(32'h0020, 32'h55, 1'b1);
    wr(32'h0030, 32'h66, 1'b1);
    pin_word("gap0", 32'h0010, 32'h0055, 1);
    idle(1'b1);
    idle(1'b1);
    #2;
    check("gap_held_valid", {31'd0, out_valid}, 32'd0);
    check("gap_held_busy", {31'd0, busy}, 32'd1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    pin_word("gap_flush", 32'h0018, 32'h0066, 1);
    idle(1'b1);

    // Odd-only byte
    wr(32'h0041, 32'h77, 1'b1);
    #2 check("odd_early", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    pin_word("odd", 32'h0020, 32'h7700, 2);
    idle(1'b1);

    // Backpressure: fill FIFO and pend, then overflow
    for (int i = 0; i < 10; i++) wr(32'h0200 + i, i + 1, 1'b0);
    #2;
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_no_ovf", {31'd0, overflow}, 32'd0);
    wr(32'h020A, 32'hEE, 1'b0);
    #2 check("bp_ovf", {31'd0, overflow}, 32'd1);
    pin_word("bp_head", 32'h0100, 32'h0201, 3);
    for (int i = 0; i < 8; i++) idle(1'b1);
    #2;
    check("bp_drained", {31'd0, busy}, 32'd0);
    check("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-stream with two FIFO entries and a partial pend
    for (int i = 0; i < 5; i++) wr(32'h0300 + i, 32'hC0 + i, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    #2;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    wr(32'h0050, 32'h12, 1'b1);
    wr(32'h0051, 32'h34, 1'b1);
    idle(1'b1);
    pin_word("mid_pair", 32'h0028, 32'h3412, 3);
    idle(1'b1);

    // Randomized stream against the model
    cursor = $urandom_range(0, 32'h7FFF);
    for (int i = 0; i < 3000; i++) begin
      we  = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 60);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) < 80) begin
        a = cursor;
      end else begin
        a = $urandom_range(0, 32'h7FFF);
      end
      if (we) cursor = (a + 1) % 32'h8000;
      cycle(we, a, $urandom_range(0, 255), fl, rdy, rst);
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    @(negedge clk_memory);
    compare_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
